// File: rtl/mig_line_adapter.sv
// Cache-line adapter onto the MIG 7-series app_* user interface.
// Each line is moved as BEATS MIG commands. An optional buffer answers repeated reads of the last line.
module mig_line_adapter #(
    parameter int APP_DATA_W = 128,
    parameter int BEATS      = 2,
    parameter int ADDR_W     = 27,
    parameter int REQ_ADDR_W = 30,
    parameter int ADDR_STEP  = 8,
    parameter int REUSE      = 1
) (
    input  logic                              ui_clk,
    input  logic                              rst,
    input  logic                              init_calib_complete,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [REQ_ADDR_W-1:0]             req_addr,
    input  logic [APP_DATA_W*BEATS-1:0]       req_wdata,
    input  logic [APP_DATA_W*BEATS/8-1:0]     req_wmask,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [APP_DATA_W*BEATS-1:0]       resp_rdata,
    output logic [ADDR_W-1:0]                 app_addr,
    output logic [2:0]                        app_cmd,
    output logic                              app_en,
    input  logic                              app_rdy,
    output logic [APP_DATA_W-1:0]             app_wdf_data,
    output logic [APP_DATA_W/8-1:0]           app_wdf_mask,
    output logic                              app_wdf_wren,
    output logic                              app_wdf_end,
    input  logic                              app_wdf_rdy,
    input  logic [APP_DATA_W-1:0]             app_rd_data,
    input  logic                              app_rd_data_valid,
    output logic                              busy,
    output logic                              err_spurious
);

    localparam int LINE_W     = APP_DATA_W * BEATS;
    localparam int MASK_W     = APP_DATA_W / 8;
    localparam int OFF        = $clog2(LINE_W / 32);
    localparam int LINE_IDX_W = REQ_ADDR_W - OFF;
    localparam int CNT_W      = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t                  state;
    logic [LINE_IDX_W-1:0]   line_q;
    logic                    write_q;
    logic [LINE_W-1:0]       wdata_q;
    logic [LINE_W/8-1:0]     wmask_q;
    logic [CNT_W-1:0]        cmd_cnt;
    logic [CNT_W-1:0]        dat_cnt;
    logic [LINE_W-1:0]       rd_line;
    logic                    reuse_vld;
    logic [LINE_IDX_W-1:0]   reuse_line;
    logic [LINE_W-1:0]       reuse_data;

    logic [LINE_IDX_W-1:0]   req_line;
    logic                    accept;
    logic                    reuse_hit;
    logic                    cmd_fire;
    logic                    wdf_fire;
    logic                    rd_fire;
    logic                    dat_inc;
    logic [CNT_W-1:0]        cmd_cnt_nxt;
    logic [CNT_W-1:0]        dat_cnt_nxt;
    logic                    unused_addr_bits;

    // Beat address wraps modulo 2^ADDR_W; the 64-bit intermediate keeps that exact.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [LINE_IDX_W-1:0] line,
                                                    input logic [CNT_W-1:0] b);
        logic [63:0] a;
        a = (64'(line) * 64'(BEATS) + 64'(b)) * 64'(ADDR_STEP);
        return a[ADDR_W-1:0];
    endfunction

    function automatic logic [APP_DATA_W-1:0] data_beat(input logic [LINE_W-1:0] line,
                                                        input logic [CNT_W-1:0] b);
        logic [APP_DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < BEATS; i++)
            if (b == CNT_W'(i)) d = line[i*APP_DATA_W +: APP_DATA_W];
        return d;
    endfunction

    function automatic logic [MASK_W-1:0] mask_beat(input logic [LINE_W/8-1:0] mask,
                                                    input logic [CNT_W-1:0] b);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < BEATS; i++)
            if (b == CNT_W'(i)) m = mask[i*MASK_W +: MASK_W];
        return m;
    endfunction

    assign unused_addr_bits = ^req_addr[OFF-1:0];
    assign req_line    = req_addr[REQ_ADDR_W-1:OFF];
    // Gating with rst keeps req_ready low while reset is held even though state reads IDLE.
    assign req_ready   = rst && (state == IDLE) && init_calib_complete;
    assign accept      = req_valid && req_ready;
    assign reuse_hit   = (REUSE != 0) && reuse_vld && (reuse_line == req_line) && !req_write;
    assign cmd_fire    = app_en && app_rdy;
    assign wdf_fire    = app_wdf_wren && app_wdf_rdy;
    assign rd_fire     = app_rd_data_valid && (state == READ) && (dat_cnt != BEATS_C);
    assign dat_inc     = (state == WRITE) ? wdf_fire : rd_fire;
    assign cmd_cnt_nxt = cmd_cnt + CNT_W'(cmd_fire);
    assign dat_cnt_nxt = dat_cnt + CNT_W'(dat_inc);
    assign resp_valid  = (state == RESP);
    assign busy        = (state != IDLE);
    assign resp_rdata  = rd_line;

    always_ff @(posedge ui_clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            line_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            cmd_cnt      <= '0;
            dat_cnt      <= '0;
            rd_line      <= '0;
            app_en       <= 1'b0;
            app_cmd      <= 3'b001;
            app_addr     <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
            err_spurious <= 1'b0;
            reuse_vld    <= 1'b0;
            reuse_line   <= '0;
            reuse_data   <= '0;
        end else begin
            if (app_rd_data_valid && state != READ)
                err_spurious <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        line_q  <= req_line;
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                        wmask_q <= req_wmask;
                        cmd_cnt <= '0;
                        dat_cnt <= '0;
                        if (reuse_hit) begin
                            rd_line <= reuse_data;
                            state   <= RESP;
                        end else if (req_write) begin
                            state        <= WRITE;
                            rd_line      <= '0;
                            app_en       <= 1'b1;
                            app_cmd      <= 3'b000;
                            app_addr     <= beat_addr(req_line, '0);
                            app_wdf_wren <= 1'b1;
                            app_wdf_end  <= 1'b1;
                            app_wdf_data <= data_beat(req_wdata, '0);
                            app_wdf_mask <= mask_beat(req_wmask, '0);
                        end else begin
                            state    <= READ;
                            app_en   <= 1'b1;
                            app_cmd  <= 3'b001;
                            app_addr <= beat_addr(req_line, '0);
                        end
                    end
                end

                // Command and data channels each retire on their own handshake.
                WRITE: begin
                    cmd_cnt <= cmd_cnt_nxt;
                    dat_cnt <= dat_cnt_nxt;
                    if (cmd_fire) begin
                        if (cmd_cnt_nxt == BEATS_C) app_en <= 1'b0;
                        else app_addr <= beat_addr(line_q, cmd_cnt_nxt);
                    end
                    if (wdf_fire) begin
                        if (dat_cnt_nxt == BEATS_C) begin
                            app_wdf_wren <= 1'b0;
                            app_wdf_end  <= 1'b0;
                        end else begin
                            app_wdf_data <= data_beat(wdata_q, dat_cnt_nxt);
                            app_wdf_mask <= mask_beat(wmask_q, dat_cnt_nxt);
                        end
                    end
                    if (cmd_cnt_nxt == BEATS_C && dat_cnt_nxt == BEATS_C)
                        state <= RESP;
                end

                READ: begin
                    cmd_cnt <= cmd_cnt_nxt;
                    dat_cnt <= dat_cnt_nxt;
                    if (cmd_fire) begin
                        if (cmd_cnt_nxt == BEATS_C) app_en <= 1'b0;
                        else app_addr <= beat_addr(line_q, cmd_cnt_nxt);
                    end
                    for (int b = 0; b < BEATS; b++)
                        if (rd_fire && dat_cnt == CNT_W'(b))
                            rd_line[b*APP_DATA_W +: APP_DATA_W] <= app_rd_data;
                    if (dat_cnt_nxt == BEATS_C) begin
                        state  <= RESP;
                        app_en <= 1'b0;
                    end
                end

                // The reuse buffer is updated only when a transfer actually completes.
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                        if (REUSE != 0) begin
                            if (!write_q) begin
                                reuse_vld  <= 1'b1;
                                reuse_line <= line_q;
                                reuse_data <= rd_line;
                            end else if (wmask_q == '0) begin
                                reuse_vld  <= 1'b1;
                                reuse_line <= line_q;
                                reuse_data <= wdata_q;
                            end else if (line_q == reuse_line) begin
                                reuse_vld  <= 1'b0;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
